// File: rtl/fp32_to_fp16_stream_converter.sv
`default_nettype none
//==============================================================================
// Module   : fp32_to_fp16_stream_converter
// Brief    : Two-stage valid/ready pipeline that narrows LENGTH lanes of FP32
//            (binary32) to FP16 (binary16) with round-to-nearest-even. It
//            produces per-lane overflow/underflow/inexact flags and saturating
//            overflow/underflow event counters.
// Revision : 1.0 - initial release
//==============================================================================
module fp32_to_fp16_stream_converter #(
    parameter int LENGTH    = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LENGTH*32-1:0]  data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [LENGTH*16-1:0]  data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [LENGTH-1:0]     overflow_out,
    output logic [LENGTH-1:0]     underflow_out,
    output logic [LENGTH-1:0]     inexact_out,
    input  logic                  count_clear_in,
    output logic [CNT_WIDTH-1:0]  overflow_count,
    output logic [CNT_WIDTH-1:0]  underflow_count,
    input  logic                  debugen_in
);

    // Lane classification codes, resolved in S1 and consumed in S2
    localparam logic [2:0] c_CLS_NAN  = 3'd0;
    localparam logic [2:0] c_CLS_INF  = 3'd1;
    localparam logic [2:0] c_CLS_ZERO = 3'd2;
    localparam logic [2:0] c_CLS_OVF  = 3'd3;
    localparam logic [2:0] c_CLS_UNF  = 3'd4;
    localparam logic [2:0] c_CLS_NORM = 3'd5;

    // Popcount and counter-sum widths; the sum is wide enough to never wrap
    localparam int c_PC_W  = $clog2(LENGTH + 1);
    localparam int c_SUM_W = CNT_WIDTH + c_PC_W;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = c_SUM_W'({CNT_WIDTH{1'b1}});

    // Per-lane state carried from S1 to S2 (exp only meaningful for NORM)
    typedef struct packed {
        logic       sign;
        logic [2:0] cls;
        logic [4:0] exp;
        logic [9:0] m10;
        logic       guard;
        logic       sticky;
        logic       nz;
    } lane_t;

    lane_t                 w_s1_lane [LENGTH];
    lane_t                 r_s1_lane [LENGTH];
    logic                  r_s1_valid;
    logic                  r_s2_valid;
    logic                  w_s1_adv;
    logic                  w_s2_adv;
    logic                  w_out_xfer;
    logic [7:0]            w_e32;
    logic [22:0]           w_mant;
    logic [9:0]            w_e16;
    logic [LENGTH*16-1:0]  w_s2_data;
    logic [LENGTH-1:0]     w_s2_ovf;
    logic [LENGTH-1:0]     w_s2_unf;
    logic [LENGTH-1:0]     w_s2_inx;
    logic [10:0]           w_sum;
    logic [4:0]            w_exp_rnd;
    logic                  w_rup;
    logic [LENGTH*16-1:0]  r_data_out;
    logic [LENGTH-1:0]     r_ovf;
    logic [LENGTH-1:0]     r_unf;
    logic [LENGTH-1:0]     r_inx;
    logic [c_PC_W-1:0]     w_ovf_pc;
    logic [c_PC_W-1:0]     w_unf_pc;
    logic [c_SUM_W-1:0]    w_ovf_sum;
    logic [c_SUM_W-1:0]    w_unf_sum;
    logic [CNT_WIDTH-1:0]  r_ovf_count;
    logic [CNT_WIDTH-1:0]  r_unf_count;

    // Stage advance: S2 drains or is empty; S1 moves whenever S2 can take it
    assign w_s2_adv   = !r_s2_valid || ready_out;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_out_xfer = r_s2_valid && ready_out;

    // S1: unpack each lane, rebias the exponent and classify the value
    always_comb begin
        w_e32  = '0;
        w_mant = '0;
        w_e16  = '0;
        for (int i = 0; i < LENGTH; i++) begin
            w_e32  = data_in[i*32+23 +: 8];
            w_mant = data_in[i*32 +: 23];
            w_e16  = {2'b00, w_e32} - 10'd112;
            w_s1_lane[i]        = '0;
            w_s1_lane[i].sign   = data_in[i*32+31];
            w_s1_lane[i].exp    = w_e16[4:0];
            w_s1_lane[i].m10    = w_mant[22:13];
            w_s1_lane[i].guard  = w_mant[12];
            w_s1_lane[i].sticky = |w_mant[11:0];
            w_s1_lane[i].nz     = |w_mant;
            if (w_e32 == 8'hFF) begin
                w_s1_lane[i].cls = (w_mant != '0) ? c_CLS_NAN : c_CLS_INF;
            end else if (w_e32 == 8'h00) begin
                w_s1_lane[i].cls = c_CLS_ZERO;
            end else if ($signed(w_e16) >= 10'sd31) begin
                w_s1_lane[i].cls = c_CLS_OVF;
            end else if ($signed(w_e16) <= 10'sd0) begin
                w_s1_lane[i].cls = c_CLS_UNF;
            end else begin
                w_s1_lane[i].cls = c_CLS_NORM;
            end
        end
    end

    // S1 register: capture a beat whenever the input handshake completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            for (int i = 0; i < LENGTH; i++) r_s1_lane[i] <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= valid_in;
            if (valid_in) r_s1_lane <= w_s1_lane;
        end
    end

    // S2: round to nearest-even, pack and derive the exception flags
    always_comb begin
        w_s2_data = '0;
        w_s2_ovf  = '0;
        w_s2_unf  = '0;
        w_s2_inx  = '0;
        w_sum     = '0;
        w_exp_rnd = '0;
        w_rup     = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            w_s2_data[i*16 +: 16] = {r_s1_lane[i].sign, 15'h0000};
            case (r_s1_lane[i].cls)
                c_CLS_NAN: w_s2_data[i*16 +: 16] = {r_s1_lane[i].sign, 5'h1F, 10'h200};
                c_CLS_INF: w_s2_data[i*16 +: 16] = {r_s1_lane[i].sign, 5'h1F, 10'h000};
                c_CLS_ZERO: w_s2_inx[i] = r_s1_lane[i].nz;
                c_CLS_OVF: begin
                    w_s2_data[i*16 +: 16] = {r_s1_lane[i].sign, 5'h1F, 10'h000};
                    w_s2_ovf[i] = 1'b1;
                    w_s2_inx[i] = 1'b1;
                end
                c_CLS_UNF: begin
                    w_s2_unf[i] = 1'b1;
                    w_s2_inx[i] = 1'b1;
                end
                default: begin
                    // A mantissa carry bumps the exponent; reaching 31 means inf
                    w_rup     = r_s1_lane[i].guard & (r_s1_lane[i].sticky | r_s1_lane[i].m10[0]);
                    w_sum     = {1'b0, r_s1_lane[i].m10} + {10'd0, w_rup};
                    w_exp_rnd = r_s1_lane[i].exp + {4'd0, w_sum[10]};
                    w_s2_inx[i] = r_s1_lane[i].guard | r_s1_lane[i].sticky;
                    if (w_exp_rnd == 5'h1F) begin
                        w_s2_data[i*16 +: 16] = {r_s1_lane[i].sign, 5'h1F, 10'h000};
                        w_s2_ovf[i] = 1'b1;
                    end else begin
                        w_s2_data[i*16 +: 16] = {r_s1_lane[i].sign, w_exp_rnd, w_sum[9:0]};
                    end
                end
            endcase
        end
    end

    // S2 register: outputs only change when the slot is free or draining
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_data_out <= '0;
            r_ovf      <= '0;
            r_unf      <= '0;
            r_inx      <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data_out <= w_s2_data;
                r_ovf      <= w_s2_ovf;
                r_unf      <= w_s2_unf;
                r_inx      <= w_s2_inx;
            end
        end
    end

    // Flag popcounts of the beat currently presented downstream
    always_comb begin
        w_ovf_pc = '0;
        w_unf_pc = '0;
        for (int i = 0; i < LENGTH; i++) begin
            w_ovf_pc = w_ovf_pc + c_PC_W'(r_ovf[i]);
            w_unf_pc = w_unf_pc + c_PC_W'(r_unf[i]);
        end
    end

    assign w_ovf_sum = c_SUM_W'(r_ovf_count) + c_SUM_W'(w_ovf_pc);
    assign w_unf_sum = c_SUM_W'(r_unf_count) + c_SUM_W'(w_unf_pc);

    // Event counters: clear wins over increment, increments saturate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_count <= '0;
            r_unf_count <= '0;
        end else if (count_clear_in) begin
            r_ovf_count <= '0;
            r_unf_count <= '0;
        end else if (w_out_xfer) begin
            r_ovf_count <= (w_ovf_sum > c_CNT_MAX) ? {CNT_WIDTH{1'b1}} : w_ovf_sum[CNT_WIDTH-1:0];
            r_unf_count <= (w_unf_sum > c_CNT_MAX) ? {CNT_WIDTH{1'b1}} : w_unf_sum[CNT_WIDTH-1:0];
        end
    end

    assign ready_in        = w_s1_adv;
    assign valid_out       = r_s2_valid;
    assign data_out        = r_data_out;
    assign overflow_out    = r_ovf;
    assign underflow_out   = r_unf;
    assign inexact_out     = r_inx;
    assign overflow_count  = r_ovf_count;
    assign underflow_count = r_unf_count;

`ifndef SYNTHESIS
    logic [LENGTH*32-1:0] r_s1_raw;
    logic [LENGTH*32-1:0] r_s2_raw;

    // Shadow of the raw input beat so the trace can show source and result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_raw <= '0;
            r_s2_raw <= '0;
        end else begin
            if (w_s1_adv && valid_in) r_s1_raw <= data_in;
            if (w_s2_adv && r_s1_valid) r_s2_raw <= r_s1_raw;
        end
    end

    // Trace of every beat accepted downstream when debug is enabled
    always_ff @(posedge clk) begin
        if (!reset && debugen_in && w_out_xfer)
            $write("%m: in=%h out=%h ovf=%b unf=%b inx=%b\n",
                   r_s2_raw, r_data_out, r_ovf, r_unf, r_inx);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_fp16_stream_converter.sv
`default_nettype none
//==============================================================================
// Module   : tb_fp32_to_fp16_stream_converter
// Brief    : Directed self-checking bench for fp32_to_fp16_stream_converter
// Revision : 1.0 - initial release
//==============================================================================
module tb_fp32_to_fp16_stream_converter;

    localparam int LENGTH    = 8;
    localparam int CNT_WIDTH = 4;

    // Directed vectors, lane 0 in the least significant word
    localparam logic [255:0] c_V1_IN  = {32'h3F803000, 32'h80000001, 32'h00000000, 32'hFF800000,
                                         32'h7FC00000, 32'hBF800000, 32'h477FE000, 32'h3F800000};
    localparam logic [127:0] c_V1_OUT = {16'h3C02, 16'h8000, 16'h0000, 16'hFC00,
                                         16'h7E00, 16'hBC00, 16'h7BFF, 16'h3C00};
    localparam logic [255:0] c_V2_IN  = {32'hC7800000, 32'h3F800000, 32'h38800000, 32'h3727C5AC,
                                         32'h47800000, 32'h477FF000, 32'h3F801001, 32'h3F801000};
    localparam logic [127:0] c_V2_OUT = {16'hFC00, 16'h3C00, 16'h0400, 16'h0000,
                                         16'h7C00, 16'h7C00, 16'h3C01, 16'h3C00};
    localparam logic [255:0] c_C_IN   = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                         32'h3F800000, 32'h3727C5AC, 32'h47800000, 32'h47800000};
    localparam logic [127:0] c_C_OUT  = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                                         16'h3C00, 16'h0000, 16'h7C00, 16'h7C00};
    localparam logic [255:0] c_S_IN   = {8{32'h47800000}};
    localparam logic [127:0] c_S_OUT  = {8{16'h7C00}};

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [LENGTH*32-1:0]  data_in = '0;
    logic                  valid_in = 1'b0;
    logic                  ready_in;
    logic [LENGTH*16-1:0]  data_out;
    logic                  valid_out;
    logic                  ready_out = 1'b1;
    logic [LENGTH-1:0]     overflow_out;
    logic [LENGTH-1:0]     underflow_out;
    logic [LENGTH-1:0]     inexact_out;
    logic                  count_clear_in = 1'b0;
    logic [CNT_WIDTH-1:0]  overflow_count;
    logic [CNT_WIDTH-1:0]  underflow_count;
    logic                  debugen_in = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp32_to_fp16_stream_converter #(
        .LENGTH    (LENGTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .valid_in        (valid_in),
        .ready_in        (ready_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .ready_out       (ready_out),
        .overflow_out    (overflow_out),
        .underflow_out   (underflow_out),
        .inexact_out     (inexact_out),
        .count_clear_in  (count_clear_in),
        .overflow_count  (overflow_count),
        .underflow_count (underflow_count),
        .debugen_in      (debugen_in)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Exact FP32 beat: lane j of beat k is 1 + (8k+j)*2^-10
    function automatic logic [255:0] make_beat(input int k);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < LENGTH; j++)
            r[j*32 +: 32] = 32'h3F800000 + (32'(k * 8 + j) << 13);
        return r;
    endfunction

    function automatic logic [255:0] exp_beat(input int k);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < LENGTH; j++)
            r[j*16 +: 16] = 16'h3C00 + 16'(k * 8 + j);
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  sent;
        int  rcvd;
        int  hold_cnt;
        bit  first_seen;
        bit  acc;
        bit  emt;
        logic [127:0] held;

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_valid_out", 256'(valid_out), 256'(1'b0));
        chk("rst_ready_in", 256'(ready_in), 256'(1'b1));
        chk("rst_data_out", 256'(data_out), 256'(0));
        chk("rst_flags", 256'({overflow_out, underflow_out, inexact_out}), 256'(0));
        chk("rst_counts", 256'({overflow_count, underflow_count}), 256'(0));

        // Basic lanes and latency
        step();
        data_in = c_V1_IN; valid_in = 1'b1; debugen_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("v1_lat_early", 256'(valid_out), 256'(1'b0));
        step();
        chk("v1_lat_valid", 256'(valid_out), 256'(1'b1));
        chk("v1_data", 256'(data_out), 256'(c_V1_OUT));
        chk("v1_inexact", 256'(inexact_out), 256'(8'hC0));
        chk("v1_ovf_unf", 256'({overflow_out, underflow_out}), 256'(0));
        step();
        debugen_in = 1'b0;
        chk("v1_drain", 256'(valid_out), 256'(1'b0));

        // Rounding and range
        data_in = c_V2_IN; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        chk("v2_valid", 256'(valid_out), 256'(1'b1));
        chk("v2_data", 256'(data_out), 256'(c_V2_OUT));
        chk("v2_overflow", 256'(overflow_out), 256'(8'h8C));
        chk("v2_underflow", 256'(underflow_out), 256'(8'h10));
        chk("v2_inexact", 256'(inexact_out), 256'(8'h9F));
        step();
        chk("v2_ovf_count", 256'(overflow_count), 256'(4'd3));
        chk("v2_unf_count", 256'(underflow_count), 256'(4'd1));
        count_clear_in = 1'b1;
        step();
        count_clear_in = 1'b0;
        chk("clear_counts", 256'({overflow_count, underflow_count}), 256'(0));

        // Backpressure: 5 beats, ready_out low for 3 cycles after first valid_out
        sent = 0; rcvd = 0; hold_cnt = 0; first_seen = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            if (valid_out && !first_seen) first_seen = 1'b1;
            if (first_seen && hold_cnt < 3) begin
                ready_out = 1'b0;
                hold_cnt++;
            end else begin
                ready_out = 1'b1;
            end
            valid_in = (sent < 5);
            data_in  = make_beat(sent);
            #1;
            if (!ready_out && hold_cnt == 1)
                chk("bp_ready_in_drop", 256'(ready_in), 256'(1'b0));
            if (!ready_out && hold_cnt > 1) begin
                chk("bp_hold_valid", 256'(valid_out), 256'(1'b1));
                chk("bp_hold_stable", 256'(data_out), 256'(held));
            end
            held = data_out;
            acc  = valid_in && ready_in;
            emt  = valid_out && ready_out;
            if (emt) begin
                chk("bp_order", 256'(data_out), exp_beat(rcvd));
                rcvd++;
            end
            step();
            if (acc) sent++;
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        chk("bp_all_received", 256'(rcvd), 256'(5));
        chk("bp_all_sent", 256'(sent), 256'(5));
        #1;
        chk("bp_no_extra", 256'(valid_out), 256'(1'b0));

        // Counters: 3 beats x (2 overflow, 1 underflow)
        step();
        data_in = c_C_IN; valid_in = 1'b1;
        step();
        step();
        chk("cnt_data", 256'(data_out), 256'(c_C_OUT));
        chk("cnt_flags", 256'({overflow_out, underflow_out}), 256'({8'h03, 8'h04}));
        step();
        valid_in = 1'b0;
        step();
        step();
        step();
        chk("cnt_ovf_6", 256'(overflow_count), 256'(4'd6));
        chk("cnt_unf_3", 256'(underflow_count), 256'(4'd3));

        // Clear coinciding with an output transfer
        data_in = c_C_IN; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        chk("clr_xfer_valid", 256'(valid_out), 256'(1'b1));
        count_clear_in = 1'b1;
        step();
        count_clear_in = 1'b0;
        chk("clr_xfer_counts", 256'({overflow_count, underflow_count}), 256'(0));

        // Saturation at 15 with 8 overflow lanes per beat
        data_in = c_S_IN; valid_in = 1'b1;
        step();
        step();
        chk("sat_data", 256'(data_out), 256'(c_S_OUT));
        step();
        valid_in = 1'b0;
        chk("sat_first", 256'(overflow_count), 256'(4'd8));
        step();
        chk("sat_clamp", 256'(overflow_count), 256'(4'd15));
        step();
        chk("sat_hold", 256'(overflow_count), 256'(4'd15));

        // Reset with two beats in flight
        step();
        data_in = make_beat(0); valid_in = 1'b1;
        step();
        data_in = make_beat(1);
        step();
        valid_in = 1'b0;
        chk("rst_mid_before", 256'(valid_out), 256'(1'b1));
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 256'(valid_out), 256'(1'b0));
        chk("rst_mid_counts", 256'({overflow_count, underflow_count}), 256'(0));
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_stale", 256'(valid_out), 256'(1'b0));
        end
        data_in = make_beat(2); valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("rst_after_early", 256'(valid_out), 256'(1'b0));
        step();
        chk("rst_after_valid", 256'(valid_out), 256'(1'b1));
        chk("rst_after_data", 256'(data_out), exp_beat(2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp32_to_fp16_stream_converter.md
Name: fp32_to_fp16_stream_converter

Overview:
- Narrowing counterpart of the FP16_5→FP32_8 widening converter: converts LENGTH-lane vectors of FP32_8 to FP16_5.
- Rounds to nearest-even; handles specials, overflow and underflow explicitly.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between FP32 datapath results and FP16 storage/transport.
- Reports per-beat exception flags and saturating event counters.

Parameters:
- LENGTH, 8, number of lanes per beat.
- CNT_WIDTH, 16, width of the overflow/underflow event counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  FP32_8[LENGTH-1:0]  input vector (LENGTH*32 bits).
- valid_in  in  1  input beat valid.
- ready_in  out  1  converter can accept a beat.
- data_out  out  FP16_5[LENGTH-1:0]  converted vector (LENGTH*16 bits).
- valid_out  out  1  output beat valid.
- ready_out  in  1  downstream accepts the beat.
- overflow_out  out  LENGTH  per-lane: result forced to ±inf by range.
- underflow_out  out  LENGTH  per-lane: nonzero result flushed to ±0.
- inexact_out  out  LENGTH  per-lane: result differs from the exact input value.
- count_clear_in  in  1  synchronous clear of both counters.
- overflow_count  out  CNT_WIDTH  saturating count of overflow lanes.
- underflow_count  out  CNT_WIDTH  saturating count of underflow lanes.
- debugen_in  in  1  enables a per-accepted-output-beat $write trace.

Behaviour:
- Reset: s1_valid, s2_valid and valid_out = 0; data_out and all flags = 0; counters = 0; ready_in = 1 on the first cycle after release.
- Reset asserted mid-stream discards in-flight beats immediately. There is no partial output.
- Transfer rule: a beat moves only when valid && ready on that interface.
- Pipeline:
  - S2 advances when !s2_valid || ready_out.
  - S1 advances when !s1_valid || S2 advances.
  - ready_in = !s1_valid || S2 advances (combinational from ready_out).
- Latency is 2 cycles from input accept to valid_out. Throughput is 1 beat/cycle when ready_out = 1.
- data_out and the flags are held stable while valid_out && !ready_out.
- S1 work: unpack each lane and compute e16 = e32 - 112 as a signed 10-bit value. Compute m10 = mant[22:13], guard = mant[12], sticky = |mant[11:0]. Classify the lane.
- S2 work: round, pack, and set flags.
- Per-lane conversion, in priority order (sign always preserved):
  - e32 = 255 and mant != 0 (NaN) → exp 31, mant 0x200 (quiet NaN). No flags.
  - e32 = 255 and mant = 0 → ±inf. No flags.
  - e32 = 0 (zero or FP32 subnormal) → ±0. inexact = (mant != 0). No underflow flag.
  - e16 >= 31 → ±inf, with overflow and inexact.
  - e16 <= 0 → ±0, with underflow and inexact. FP16 subnormals are not generated.
  - Otherwise (normal case):
    - Round up when guard && (sticky || m10[0]).
    - If m10 + 1 carries out, mant = 0 and exp = e16 + 1.
    - If that exp reaches 31, the result is ±inf with overflow and inexact.
    - inexact = guard || sticky.
- Counters:
  - On each output transfer, add popcount(overflow_out) and popcount(underflow_out).
  - Each counter saturates at 2^CNT_WIDTH-1.
  - count_clear_in has priority over a same-cycle increment: the result is 0.
- debugen_in: on each output transfer, print data_in, data_out and the three flag vectors. This has no functional effect.

Test Plan:
- Lane values 0x3F800000, 0x477FE000, 0xBF800000, 0x7FC00000, 0xFF800000, 0x00000000, 0x80000001, 0x3F803000 → outputs 0x3C00, 0x7BFF, 0xBC00, 0x7E00, 0xFC00, 0x0000, 0x8000 (inexact), 0x3C02 (inexact). valid_out rises exactly 2 cycles after accept.
- Rounding: 0x3F801000 (tie, even LSB) → 0x3C00 inexact. 0x3F801001 → 0x3C01 inexact. 0x477FF000 → carry to 0x7C00 with overflow and inexact.
- Range: 0x47800000 (65536) → 0x7C00 overflow. 0x3727C5AC (1e-5) → 0x0000 underflow. 0x38800000 (2^-14) → 0x0400 with no flags.
- Backpressure: stream 5 beats back-to-back with ready_out held low for 3 cycles after the first valid_out:
  - ready_in drops once 2 beats are buffered.
  - data_out stays stable while held.
  - All 5 beats emerge in order with none lost or duplicated.
- Counters: LENGTH=8, 3 beats each carrying 2 overflow lanes and 1 underflow lane → overflow_count = 6, underflow_count = 3.
  - count_clear_in in the same cycle as a transfer → both counters 0.
  - With CNT_WIDTH = 4, further overflow beats saturate the count at 15.
- Reset mid-operation: assert reset with 2 beats in flight → valid_out drops immediately and counters clear. After release, no stale beat ever appears and the next input emerges 2 cycles after accept.
